apb_slave_mem: RTL



---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_regbank.sv | 31 +++
 rtl/apb_slave_mem.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared state type, wait counter width and address helper for the
// APB slave memory bank.
package apb_pkg;

  // Transfer sequencing as seen from the slave side of the bus.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Width of the wait-state counter (covers WAIT_STATES up to 15).
  localparam int WAIT_W = 4;

  // Number of word-index bits needed to address a bank of the given depth.
  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// apb_regbank: one DEPTH x DATA_WIDTH storage array with a synchronous write
// port and a registered read port. The read register samples the array every
// cycle, so data is available one cycle after the address is presented.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [index_width(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [index_width(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write on request and unconditional registered read.
  // NOTE: the array and its read register carry no reset so the storage maps
  // onto plain RAM; sequential state always uses non-blocking assignments so
  // the read sees the pre-write contents in the same cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: bank of NUM_SLAVES memory-backed APB targets with
// programmable wait states, error response on misaligned or multi-select
// transfers, and a sticky protocol-violation flag.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_SLAVES-1:0] pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  proto_err
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;

  // Attributes of the transfer in flight, captured when it is accepted.
  logic [SEL_W-1:0]      sel_q;
  logic [IDX_W-1:0]      index_q;
  logic                  pwrite_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  logic                  any_sel, multi_sel, misaligned, start;
  logic [SEL_W-1:0]      sel_lowest;
  logic [IDX_W-1:0]      rd_index;
  logic                  proto_viol, mem_we, rd_load;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_SLAVES];

  // Upper address bits only alias the array; they are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^paddr[ADDR_WIDTH-1:IDX_W+2];

  // Decode of the incoming bus request.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    any_sel    = |pselx;
    multi_sel  = |(pselx & (pselx - NUM_SLAVES'(1)));
    misaligned = |paddr[1:0];
    sel_lowest = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (pselx[i]) sel_lowest = SEL_W'(i);
    end
    start    = (state == IDLE) && any_sel && !penable;
    // Look up the new address while still idle so the bank output is ready
    // by the time the transfer can complete.
    rd_index = (state == IDLE) ? paddr[IDX_W+1:2] : index_q;
  end

  // State and wait-counter register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state and wait-counter update.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      IDLE: begin
        // A request arriving with penable already high is dropped.
        if (any_sel && !penable) begin
          state_next    = SETUP;
          wait_cnt_next = WAIT_W'(WAIT_STATES);
        end
      end
      SETUP: begin
        state_next = penable ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (wait_cnt == '0) begin
          state_next = IDLE;
        end else if (!any_sel) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt - WAIT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus responses, violation detection and memory/read-data strobes.
  always_comb begin
    pready     = (state == ACCESS) && (wait_cnt == '0);
    pslverr    = pready && err_q;
    proto_viol = ((state == IDLE) && penable) ||
                 ((state == SETUP) && !penable) ||
                 ((state == ACCESS) && (wait_cnt != '0) && !any_sel);
    // A reset landing on the completing cycle must not commit the write.
    mem_we     = pready && pwrite_q && !err_q && !hreset;
    // Load prdata on the edge that enters the completing cycle so the data
    // is already presented while pready is high.
    rd_load    = (state_next == ACCESS) && (wait_cnt_next == '0) && !pwrite_q;
  end

  // Capture the control attributes of an accepted transfer.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_q    <= '0;
      index_q  <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (start) begin
      sel_q    <= sel_lowest;
      index_q  <= paddr[IDX_W+1:2];
      pwrite_q <= pwrite;
      err_q    <= multi_sel || misaligned;
    end
  end

  // Capture write data at acceptance; later pwdata changes are ignored.
  always_ff @(posedge hclk) begin
    if (start) begin
      pwdata_q <= pwdata;
    end
  end

  // Registered read data and sticky violation flag.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      prdata    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (rd_load) begin
        prdata <= err_q ? '0 : bank_rdata[sel_q];
      end
      if (proto_viol) begin
        proto_err <= 1'b1;
      end
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_bank
    apb_regbank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_bank (
      .clk  (hclk),
      .we   (mem_we && (sel_q == SEL_W'(s))),
      .waddr(index_q),
      .wdata(pwdata_q),
      .raddr(rd_index),
      .rdata(bank_rdata[s])
    );
  end

endmodule
